// File: rtl/pq_pkg.sv
// pq_pkg: shared types and constants for the priority-queue front end.
//   pq_op_e      - per-requester operation code (2 bits)
//   arb_state_e  - access FSM states
//   PQ_EMPTY_VALUE - slot value the queue treats as "no entry"; enqueuing it
//                    would corrupt the heap, so such requests are rejected.
package pq_pkg;

  typedef enum logic [1:0] {
    PEEK    = 2'b00,
    ENQ     = 2'b01,
    DEQ     = 2'b10,
    REPLACE = 2'b11
  } pq_op_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } arb_state_e;

  localparam int PQ_EMPTY_VALUE = 0;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     - candidate vector (already qualified by the caller)
//   ptr     - highest-priority index this cycle
//   gnt     - one-hot grant (zero when no candidate)
//   gnt_idx - binary index of the grant
//   gnt_any - at least one candidate present
// The scan starts at ptr and wraps N-1 -> 0; the pointer register lives
// with the caller.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int IW = $clog2(N);

  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!gnt_any && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pq_access_arbiter.sv
// pq_access_arbiter: shares one pipelined register-tree priority queue among
// NUM_REQ requesters.
//   i_CLK, i_RSTn            - clock, async active-low reset
//   i_req_valid/op/data      - per-requester request (op k at [2k+1:2k])
//   o_req_ready              - one-hot, combinational accept (ARB only)
//   o_rsp_valid/id/data/err  - one response per accepted request, cycle after
//   o_pq_wrt/read/data       - one-cycle queue strobes
//   i_pq_full/empty/data     - queue status and current root
// After any strobe the FSM idles SETTLE_CYCLES so the tree can re-heapify.
module pq_access_arbiter
  import pq_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                            i_CLK,
  input  logic                            i_RSTn,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [2*NUM_REQ-1:0]            i_req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic                            o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]      o_rsp_id,
  output logic [DATA_WIDTH-1:0]           o_rsp_data,
  output logic                            o_rsp_err,
  output logic                            o_pq_wrt,
  output logic                            o_pq_read,
  output logic [DATA_WIDTH-1:0]           o_pq_data,
  input  logic                            i_pq_full,
  input  logic                            i_pq_empty,
  input  logic [DATA_WIDTH-1:0]           i_pq_data
);

  localparam int IW          = $clog2(NUM_REQ);
  localparam int CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
    logic          err;
    logic          use_root;  // response carries the live root (not ENQ)
  } rsp_t;

  logic [NUM_REQ-1:0][1:0]            op_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
  logic [NUM_REQ-1:0]                 cand;
  logic [NUM_REQ-1:0]                 gnt;
  logic [IW-1:0]                      gnt_idx;
  logic                               gnt_any;

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   rr_ptr_q;
  rsp_t            rsp_q;
  logic            wrt_q, read_q;
  logic [DATA_WIDTH-1:0] pq_data_q;

  assign op_a   = i_req_op;
  assign data_a = i_req_data;

  // Ineligible requesters drop out of the candidate set so they never block
  // others; they simply stay valid until the flags allow them.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_elig
    assign cand[k] = i_req_valid[k] &
                     ((op_a[k] == ENQ) ? !i_pq_full  :
                      (op_a[k] == DEQ) ? !i_pq_empty : 1'b1);
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (cand),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  logic                  accept;
  pq_op_e                gop;
  logic [DATA_WIDTH-1:0] gdata;
  logic                  rej, wrt_d, read_d;

  assign accept      = (state_q == ARB) && gnt_any;
  assign o_req_ready = (state_q == ARB) ? gnt : '0;
  assign gop         = pq_op_e'(op_a[gnt_idx]);
  assign gdata       = data_a[gnt_idx];
  assign rej         = (gop == ENQ) && (gdata == DATA_WIDTH'(PQ_EMPTY_VALUE));
  assign wrt_d       = ((gop == ENQ) && !rej) || (gop == REPLACE);
  assign read_d      = (gop == DEQ) || (gop == REPLACE);

  // Issue stage: strobes and response metadata for one cycle after accept.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      rsp_q     <= '0;
      wrt_q     <= 1'b0;
      read_q    <= 1'b0;
      pq_data_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      rsp_q     <= '0;
      wrt_q     <= 1'b0;
      read_q    <= 1'b0;
      pq_data_q <= '0;
      if (accept) begin
        rsp_q.valid    <= 1'b1;
        rsp_q.id       <= gnt_idx;
        rsp_q.err      <= rej;
        rsp_q.use_root <= (gop != ENQ);
        wrt_q          <= wrt_d;
        read_q         <= read_d;
        pq_data_q      <= wrt_d ? gdata : '0;
        rr_ptr_q       <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // The queue acts on the strobe edge at the end of the issue cycle, so the
  // root seen during the issue cycle is still the pre-op value.
  assign o_rsp_valid = rsp_q.valid;
  assign o_rsp_id    = rsp_q.id;
  assign o_rsp_err   = rsp_q.err;
  assign o_rsp_data  = rsp_q.use_root ? i_pq_data : '0;
  assign o_pq_wrt    = wrt_q;
  assign o_pq_read   = read_q;
  assign o_pq_data   = pq_data_q;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ISSUE && state_d == SETTLE)
        cnt_q <= CW'(SETTLE_LOAD);
      else if (state_q == SETTLE && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:    if (accept) state_d = ISSUE;
      ISSUE:  state_d = ((wrt_q || read_q) && SETTLE_CYCLES > 0) ? SETTLE : ARB;
      SETTLE: if (cnt_q == '0) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

endmodule

// File: tb/tb_pq_access_arbiter.sv
module tb_pq_access_arbiter;
  import pq_pkg::*;

  logic        i_CLK = 1'b0;
  logic        i_RSTn;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [63:0] req_data;
  logic [3:0]  ready;
  logic        rsp_valid, rsp_err, pq_wrt, pq_read;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data, pq_wdata;
  logic        pq_full, pq_empty;
  logic [15:0] pq_root;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_CLK = ~i_CLK;

  pq_access_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .SETTLE_CYCLES(2)) dut (
    .i_CLK       (i_CLK),
    .i_RSTn      (i_RSTn),
    .i_req_valid (req_valid),
    .i_req_op    (req_op),
    .i_req_data  (req_data),
    .o_req_ready (ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_pq_wrt    (pq_wrt),
    .o_pq_read   (pq_read),
    .o_pq_data   (pq_wdata),
    .i_pq_full   (pq_full),
    .i_pq_empty  (pq_empty),
    .i_pq_data   (pq_root)
  );

  wire [41:0] all_out = {ready, rsp_valid, rsp_id, rsp_data, rsp_err,
                         pq_wrt, pq_read, pq_wdata};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_CLK);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input pq_op_e op, input logic [15:0] d);
    req_valid[k]        = v;
    req_op[2*k +: 2]    = op;
    req_data[16*k +: 16] = d;
  endtask

  initial begin
    i_RSTn = 1'b0; req_valid = '0; req_op = '0; req_data = '0;
    pq_full = 1'b0; pq_empty = 1'b1; pq_root = '0;
    repeat (3) tick;
    chk("rst_out", 64'(all_out), 64'd0);
    i_RSTn = 1'b1;

    // 1: idle
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_out", 64'(all_out), 64'd0);
    end

    // 2: ENQ 0x0050 on empty queue, gap before next grant
    set_req(0, 1'b1, ENQ, 16'h0050); #1;
    chk("t2_rdy", 64'(ready), 64'b0001);
    tick;                                       // T+1
    set_req(0, 1'b0, PEEK, 16'h0);
    set_req(1, 1'b1, DEQ, 16'h0);
    set_req(2, 1'b1, PEEK, 16'h0);
    chk("t2_strobe", 64'({pq_wrt, pq_read}), 64'b10);
    chk("t2_wdata", 64'(pq_wdata), 64'h0050);
    chk("t2_rsp", 64'({rsp_valid, rsp_id, rsp_err}), 64'b1_00_0);
    chk("t2_rdata", 64'(rsp_data), 64'h0);
    chk("t2_rdy_iss", 64'(ready), 64'd0);
    tick;                                       // T+2
    pq_empty = 1'b0; pq_root = 16'h0090; #1;
    chk("t2_gap2", 64'({ready, pq_wrt, pq_read}), 64'd0);
    tick; #1;                                   // T+3
    chk("t2_gap3", 64'(ready), 64'd0);

    // 3: pointer=1, DEQ at req1 beats PEEK at req2
    tick; #1;                                   // T+4
    chk("t3_rdy1", 64'(ready), 64'b0010);
    tick;
    set_req(1, 1'b0, PEEK, 16'h0);
    chk("t3_strobe", 64'({pq_wrt, pq_read}), 64'b01);
    chk("t3_rsp", 64'({rsp_valid, rsp_id, rsp_err}), 64'b1_01_0);
    chk("t3_rdata", 64'(rsp_data), 64'h0090);
    tick;
    pq_root = 16'h0042;
    tick; #1;
    chk("t3_gap", 64'(ready), 64'd0);
    tick; #1;
    chk("t3_rdy2", 64'(ready), 64'b0100);
    tick;
    set_req(2, 1'b0, PEEK, 16'h0);
    chk("t3_peek_rsp", 64'({rsp_valid, rsp_id, pq_wrt, pq_read}), 64'b1_10_00);
    chk("t3_peek_data", 64'(rsp_data), 64'h0042);
    tick;                                       // PEEK: straight back to ARB
    set_req(0, 1'b1, PEEK, 16'h0);
    set_req(3, 1'b1, PEEK, 16'h0); #1;
    chk("t3_ptr3", 64'(ready), 64'b1000);
    tick;
    set_req(3, 1'b0, PEEK, 16'h0);
    chk("t3_rsp3", 64'({rsp_valid, rsp_id}), 64'b1_11);
    tick; #1;
    chk("t3_wrap", 64'(ready), 64'b0001);
    tick;
    set_req(0, 1'b0, PEEK, 16'h0);
    chk("t3_rsp0", 64'({rsp_valid, rsp_id}), 64'b1_00);
    tick;

    // 4: DEQ on empty skipped, ENQ from req3 served first
    pq_empty = 1'b1; pq_root = 16'h0;
    set_req(0, 1'b1, DEQ, 16'h0);
    set_req(3, 1'b1, ENQ, 16'h0007); #1;
    chk("t4_skip", 64'(ready), 64'b1000);
    tick;
    set_req(3, 1'b0, PEEK, 16'h0);
    chk("t4_enq", 64'({pq_wrt, pq_read, rsp_valid, rsp_id}), 64'b10_1_11);
    chk("t4_wdata", 64'(pq_wdata), 64'h0007);
    tick;
    pq_empty = 1'b0; pq_root = 16'h0007; #1;
    chk("t4_gap", 64'(ready), 64'd0);
    tick; tick; #1;
    chk("t4_rdy0", 64'(ready), 64'b0001);
    tick;
    set_req(0, 1'b0, PEEK, 16'h0);
    chk("t4_deq", 64'({pq_read, rsp_valid, rsp_id}), 64'b1_1_00);
    chk("t4_rdata", 64'(rsp_data), 64'h0007);
    tick;
    pq_empty = 1'b1; pq_root = 16'h0;
    tick; tick;

    // 5: ENQ blocked while full
    pq_full = 1'b1; pq_empty = 1'b0; pq_root = 16'h0030;
    set_req(2, 1'b1, ENQ, 16'h0011);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t5_full", 64'(ready), 64'd0);
      tick;
    end
    pq_full = 1'b0; #1;
    chk("t5_rdy", 64'(ready), 64'b0100);
    tick;
    set_req(2, 1'b0, PEEK, 16'h0);
    chk("t5_enq", 64'({pq_wrt, rsp_valid, rsp_id}), 64'b1_1_10);
    chk("t5_wdata", 64'(pq_wdata), 64'h0011);
    tick; tick; tick;

    // 6: ENQ of 0 rejected without settle, then reset during SETTLE
    set_req(1, 1'b1, ENQ, 16'h0000); #1;
    chk("t6_rdy", 64'(ready), 64'b0010);
    tick;
    set_req(1, 1'b0, PEEK, 16'h0);
    set_req(3, 1'b1, PEEK, 16'h0);
    chk("t6_err", 64'({rsp_valid, rsp_id, rsp_err, pq_wrt, pq_read}), 64'b1_01_1_00);
    chk("t6_rdata", 64'(rsp_data), 64'h0);
    tick; #1;
    chk("t6_nosettle", 64'(ready), 64'b1000);
    tick;
    set_req(3, 1'b0, PEEK, 16'h0);
    set_req(0, 1'b1, DEQ, 16'h0);
    chk("t6_peek", 64'({rsp_valid, rsp_id}), 64'b1_11);
    chk("t6_peek_data", 64'(rsp_data), 64'h0030);
    tick; #1;
    chk("t6_rdy0", 64'(ready), 64'b0001);
    tick;
    set_req(0, 1'b0, PEEK, 16'h0);
    chk("t6_read", 64'(pq_read), 64'd1);
    tick;                                       // first SETTLE cycle
    chk("t6_settle", 64'({pq_read, rsp_valid}), 64'd0);
    #2 i_RSTn = 1'b0;
    #1;
    chk("t6_async_rst", 64'(all_out), 64'd0);
    tick; tick;
    i_RSTn = 1'b1;
    set_req(0, 1'b1, PEEK, 16'h0);
    set_req(3, 1'b1, PEEK, 16'h0); #1;
    chk("t6_post_rst", 64'(ready), 64'b0001);
    tick;
    set_req(0, 1'b0, PEEK, 16'h0);
    set_req(3, 1'b0, PEEK, 16'h0);
    chk("t6_post_rsp", 64'({rsp_valid, rsp_id}), 64'b1_00);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
